fillbox_sched: RTL and testbench
================================

# fillbox_sched

Command scheduler for the fillbox accelerator. It accepts fill-box commands (VRAM base, width, height) from two requesters and queues them in a shared FIFO. It issues them one at a time to the single fillbox engine, using the engine's `start`/`done` pulse handshake, and raises a watchdog error if the engine never reports completion. It sits between the software-facing register blocks and the fillbox engine.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `TIMEOUT`, default 24'd4000000: maximum cycles from `start` to `done` before abort.
- `GAP`, default 2: idle cycles between an accepted `done` and the next `start`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-high.
- `a_valid`  in  1: requester A command valid.
- `a_ready`  out  1: requester A accepted this cycle; asserted only when `a_valid` is high.
- `a_vram`  in  28: requester A base address.
- `a_width`  in  10: requester A width in pixels.
- `a_height`  in  10: requester A height in lines.
- `b_valid`, `b_ready`, `b_vram`, `b_width`, `b_height`: same meanings as the A ports, for requester B.
- `vram`  out  28: engine base address.
- `width`  out  10: engine width.
- `height`  out  10: engine height.
- `start`  out  1: one-cycle engine launch pulse.
- `done`  in  1: one-cycle engine completion pulse.
- `busy`  out  1: high while a command is in flight or the FIFO is non-empty.
- `level`  out  5: current FIFO occupancy, 0..DEPTH.
- `done_count`  out  16: commands completed since reset; wraps from 0xFFFF to 0.
- `err_timeout`  out  1: sticky flag; cleared only by `rst`.

## Operation
- **Arbitration (write side)**
  - A candidate is a requester whose `valid` is high and whose command has non-zero width and non-zero height.
  - At most one requester is accepted per cycle, and only when the FIFO is not full.
  - If both are candidates, round-robin decides: the requester not granted last wins. After reset A has priority.
  - `x_ready` is high in the same cycle the command is written, as a combinational function of `valid`, FIFO full and the priority register.
- **Zero-size commands**
  - A command with width==0 or height==0 is accepted (its `ready` pulses) but is not written to the FIFO and is not counted.
  - Such commands are never launched, because the engine produces no `done` for height 0.
  - A zero-size command does not consume a FIFO slot, so it is accepted even when the FIFO is full.
  - It also does not change round-robin priority.
- **Sequencer FSM**
  - IDLE: if the FIFO is non-empty, pop the head into the `vram`/`width`/`height` registers and go to LAUNCH.
  - LAUNCH: `start`=1 for exactly this one cycle; clear the watchdog counter; go to RUN.
  - RUN: on `done`, increment `done_count` and go to GAP. If the watchdog counter reaches TIMEOUT first, set `err_timeout` and go to GAP.
  - GAP: hold for GAP cycles, then go to IDLE.
- `done` is ignored in every state except RUN. This covers the engine's spurious pulse after power-up.
- `vram`/`width`/`height` stay stable from LAUNCH until the next pop.
- A simultaneous push and pop on a non-empty FIFO leaves `level` unchanged.
- A pop from a FIFO that was empty at the cycle start is not possible: push data becomes poppable one cycle later.
- `busy` = (state != IDLE) or (level != 0).

## Timing
- Reset values:
  - Outputs: `start`=0, `a_ready`=`b_ready`=0, `vram`=0, `width`=0, `height`=0, `busy`=0, `level`=0, `done_count`=0, `err_timeout`=0.
  - Internal: state IDLE, FIFO empty, priority to A.
- Latency from a push into an empty FIFO to `start` is 2 cycles: push at cycle N, pop at N+1 (IDLE), `start` at N+2.
- Minimum spacing from `done` (cycle D, RUN) to the next `start`: GAP runs D+1..D+GAP, IDLE at D+GAP+1, `start` at D+GAP+2.
- Watchdog: a 24-bit counter increments every RUN cycle. The abort fires in the cycle the count equals TIMEOUT-1 with no `done`.
- If `done` and the timeout coincide, `done` wins: counted, no error.
- `rst` mid-operation:
  - Flushes the FIFO and aborts any in-flight command without waiting for `done`.
  - Any `start` pulse in that cycle is suppressed.
  - The team resets the engine separately.

## Test plan
- A only: push (vram=0x100, w=20, h=3); `done` returned 50 cycles after `start` -> `start` 2 cycles after push, outputs 0x100/20/3, `done_count`=1, `busy` low 3 cycles after `done` (with GAP=2).
- A and B valid every cycle with distinct commands, DEPTH=4 -> acceptance order A,B,A,B; `ready` deasserts at `level`=4; launch order matches acceptance.
- Zero-size: B sends w=0, then h=0, then w=5/h=1 -> first two `ready`s pulse with no `start`; exactly one `start` with width 5; `done_count`=1.
- Spurious `done` in IDLE and during GAP -> no count change, no extra `start`.
- TIMEOUT=16, engine never pulses `done` -> `err_timeout` set 16 cycles after `start`; the next queued command launches GAP+2 cycles later; the flag stays set.
- `rst` asserted during RUN with 3 queued commands -> next cycle `level`=0, `busy`=0, no `start` for 10 cycles afterward.

Source files
------------

// File: rtl/fillbox_sched.sv
`default_nettype none
// ============================================================================
// Module : fillbox_sched
// Two-requester fill-box command queue feeding a single start/done engine.
// Rev    : 1.0
// ============================================================================
module fillbox_sched #(
   parameter int          DEPTH   = 4,
   parameter logic [23:0] TIMEOUT = 24'd4000000,
   parameter int          GAP     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [27:0] a_vram,
   input  logic [9:0]  a_width,
   input  logic [9:0]  a_height,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [27:0] b_vram,
   input  logic [9:0]  b_width,
   input  logic [9:0]  b_height,
   output logic [27:0] vram,
   output logic [9:0]  width,
   output logic [9:0]  height,
   output logic        start,
   input  logic        done,
   output logic        busy,
   output logic [4:0]  level,
   output logic [15:0] done_count,
   output logic        err_timeout
);

   localparam int          c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0]  c_DEPTH     = 5'(DEPTH);
   localparam logic [23:0] c_WDOG_LAST = TIMEOUT - 24'd1;
   localparam logic [7:0]  c_GAP_LAST  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_GAP    = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [47:0]     r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [4:0]      r_level;
   logic            r_prio_b;
   logic [23:0]     r_wdog;
   logic [7:0]      r_gap_cnt;
   logic [27:0]     r_vram;
   logic [9:0]      r_width;
   logic [9:0]      r_height;
   logic [15:0]     r_done_cnt;
   logic            r_err;

   logic            w_full;
   logic            w_a_cand;
   logic            w_b_cand;
   logic            w_a_elig;
   logic            w_b_elig;
   logic            w_a_win;
   logic            w_b_win;
   logic            w_push;
   logic [47:0]     w_push_data;
   logic            w_pop;
   logic            w_start;
   logic            w_done_ok;
   logic            w_abort;

   // ---------------- write-side arbitration ----------------
   // Zero-size commands need no FIFO slot, so they stay eligible when full.
   always_comb begin
      w_full   = (r_level == c_DEPTH);
      w_a_cand = a_valid && (a_width != 10'd0) && (a_height != 10'd0);
      w_b_cand = b_valid && (b_width != 10'd0) && (b_height != 10'd0);
      w_a_elig = a_valid && !rst && (!w_a_cand || !w_full);
      w_b_elig = b_valid && !rst && (!w_b_cand || !w_full);
      w_a_win  = w_a_elig && (!w_b_elig || !r_prio_b);
      w_b_win  = w_b_elig && !w_a_win;
      w_push   = (w_a_win && w_a_cand) || (w_b_win && w_b_cand);
      w_push_data = w_a_win ? {a_vram, a_width, a_height}
                            : {b_vram, b_width, b_height};
   end

   assign a_ready = w_a_win;
   assign b_ready = w_b_win;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prio_b <= 1'b0;
      end else if (w_a_win && w_a_cand) begin
         r_prio_b <= 1'b1;
      end else if (w_b_win && w_b_cand) begin
         r_prio_b <= 1'b0;
      end
   end

   // ---------------- command FIFO ----------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= 5'd0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 5'd1;
            2'b01:   r_level <= r_level - 5'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // ---------------- sequencer FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_start     = 1'b0;
      w_done_ok   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_level != 5'd0) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            w_start     = 1'b1;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            // A done arriving on the last watchdog cycle still counts as success.
            if (done) begin
               w_done_ok   = 1'b1;
               w_state_nxt = S_GAP;
            end else if (r_wdog == c_WDOG_LAST) begin
               w_abort     = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (r_gap_cnt >= c_GAP_LAST) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdog     <= 24'd0;
         r_gap_cnt  <= 8'd0;
         r_vram     <= 28'd0;
         r_width    <= 10'd0;
         r_height   <= 10'd0;
         r_done_cnt <= 16'd0;
         r_err      <= 1'b0;
      end else begin
         if (r_state == S_LAUNCH) begin
            r_wdog <= 24'd0;
         end else if (r_state == S_RUN) begin
            r_wdog <= r_wdog + 24'd1;
         end
         if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
         end else begin
            r_gap_cnt <= 8'd0;
         end
         if (w_pop) begin
            {r_vram, r_width, r_height} <= r_mem[r_rd_ptr];
         end
         if (w_done_ok) begin
            r_done_cnt <= r_done_cnt + 16'd1;
         end
         if (w_abort) begin
            r_err <= 1'b1;
         end
      end
   end

   assign start       = w_start && !rst;
   assign vram        = r_vram;
   assign width       = r_width;
   assign height      = r_height;
   assign level       = r_level;
   assign busy        = (r_state != S_IDLE) || (r_level != 5'd0);
   assign done_count  = r_done_cnt;
   assign err_timeout = r_err || (w_abort && !rst);

endmodule
`default_nettype wire

// File: tb/tb_fillbox_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_fillbox_sched
// Directed self-checking bench for fillbox_sched (DEPTH=4, TIMEOUT=60, GAP=2).
// Rev    : 1.0
// ============================================================================
module tb_fillbox_sched;

   localparam int          DEPTH   = 4;
   localparam logic [23:0] TIMEOUT = 24'd60;
   localparam int          GAP     = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic        a_ready;
   logic [27:0] a_vram = '0;
   logic [9:0]  a_width = '0;
   logic [9:0]  a_height = '0;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic [27:0] b_vram = '0;
   logic [9:0]  b_width = '0;
   logic [9:0]  b_height = '0;
   logic [27:0] vram;
   logic [9:0]  width;
   logic [9:0]  height;
   logic        start;
   logic        done = 1'b0;
   logic        busy;
   logic [4:0]  level;
   logic [15:0] done_count;
   logic        err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   fillbox_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_vram(a_vram), .a_width(a_width), .a_height(a_height),
      .b_valid(b_valid), .b_ready(b_ready), .b_vram(b_vram), .b_width(b_width), .b_height(b_height),
      .vram(vram), .width(width), .height(height), .start(start), .done(done),
      .busy(busy), .level(level), .done_count(done_count), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      a_valid = 1'b0;
      b_valid = 1'b0;
      done    = 1'b0;
      rst     = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_valid = 1'b1; a_vram = 28'h55; a_width = 10'd3; a_height = 10'd3;
      tick();
      tick();
      #1;
      n_checks++;
      if ({start, a_ready, b_ready, busy, err_timeout} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 00000", {start, a_ready, b_ready, busy, err_timeout});
      end
      n_checks++;
      if ({vram, width, height} !== 48'h0) begin
         n_fail++; $display("FAIL reset_cmd: got %h want 0", {vram, width, height});
      end
      n_checks++;
      if ({level, done_count} !== 21'h0) begin
         n_fail++; $display("FAIL reset_counts: level=%0d done_count=%0d want 0/0", level, done_count);
      end
      a_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      a_valid = 1'b1; a_vram = 28'h100; a_width = 10'd20; a_height = 10'd3;
      #1;
      n_checks++;
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", a_ready); end
      tick();
      a_valid = 1'b0;
      n_checks++;
      if ({start, level, busy} !== {1'b0, 5'd1, 1'b1}) begin
         n_fail++; $display("FAIL single_queued: start=%b level=%0d busy=%b want 0/1/1", start, level, busy);
      end
      tick();
      n_checks++;
      if ({start, vram, width, height} !== {1'b1, 28'h100, 10'd20, 10'd3}) begin
         n_fail++; $display("FAIL single_launch: start=%b vram=%h w=%0d h=%0d want 1/100/20/3", start, vram, width, height);
      end
      for (int i = 0; i < 50; i++) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if ({done_count, busy, start} !== {16'd1, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL single_done: count=%0d busy=%b start=%b want 1/1/0", done_count, busy, start);
      end
      tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_gap2: got %b want 1", busy); end
      tick();
      n_checks++;
      if ({busy, vram, width, height} !== {1'b0, 28'h100, 10'd20, 10'd3}) begin
         n_fail++; $display("FAIL single_idle: busy=%b vram=%h w=%0d h=%0d want 0/100/20/3", busy, vram, width, height);
      end
   endtask

   task automatic test_back_to_back();
      bit [5:0]    exp_a;
      bit [5:0]    exp_b;
      logic [27:0] exp_v [4];
      logic [9:0]  exp_w [4];
      int ai;
      int bi;
      int cnt;
      exp_a = 6'b010101;
      exp_b = 6'b001010;
      exp_v[0] = 28'h2000; exp_w[0] = 10'd30;
      exp_v[1] = 28'h1001; exp_w[1] = 10'd11;
      exp_v[2] = 28'h2001; exp_w[2] = 10'd31;
      exp_v[3] = 28'h1002; exp_w[3] = 10'd12;
      ai = 0;
      bi = 0;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         a_valid = 1'b1; a_vram = 28'h1000 + 28'(ai); a_width = 10'(10 + ai); a_height = 10'd2;
         b_valid = 1'b1; b_vram = 28'h2000 + 28'(bi); b_width = 10'(30 + bi); b_height = 10'd4;
         #1;
         n_checks++;
         if ({a_ready, b_ready} !== {exp_a[c], exp_b[c]}) begin
            n_fail++; $display("FAIL b2b_grant[%0d]: a/b ready=%b%b want %b%b", c, a_ready, b_ready, exp_a[c], exp_b[c]);
         end
         if (c == 2) begin
            n_checks++;
            if ({start, vram, width} !== {1'b1, 28'h1000, 10'd10}) begin
               n_fail++; $display("FAIL b2b_first_launch: start=%b vram=%h w=%0d want 1/1000/10", start, vram, width);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (level !== 5'd4) begin n_fail++; $display("FAIL b2b_full_level: got %0d want 4", level); end
         end
         if (exp_a[c]) ai++;
         if (exp_b[c]) bi++;
         tick();
      end
      b_valid = 1'b0;
      a_width = 10'd0;
      #1;
      n_checks++;
      if (a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_zero_when_full: ready=%b want 1", a_ready); end
      tick();
      a_valid = 1'b0;
      n_checks++;
      if (level !== 5'd4) begin n_fail++; $display("FAIL b2b_zero_no_slot: level=%0d want 4", level); end
      for (int k = 0; k < 4; k++) begin
         tick();
         done = 1'b1;
         tick();
         done = 1'b0;
         cnt = 0;
         while (start !== 1'b1 && cnt < 10) begin
            tick();
            cnt++;
         end
         n_checks++;
         if ({cnt, vram, width} !== {32'(GAP + 1), exp_v[k], exp_w[k]}) begin
            n_fail++; $display("FAIL b2b_launch[%0d]: wait=%0d vram=%h w=%0d want %0d/%h/%0d", k, cnt, vram, width, GAP + 1, exp_v[k], exp_w[k]);
         end
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (done_count !== 16'd5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", done_count); end
      tick(); tick(); tick();
      n_checks++;
      if ({busy, level} !== {1'b0, 5'd0}) begin
         n_fail++; $display("FAIL b2b_drained: busy=%b level=%0d want 0/0", busy, level);
      end
   endtask

   task automatic test_zero_size();
      int ns;
      do_reset();
      b_valid = 1'b1; b_vram = 28'h700; b_width = 10'd0; b_height = 10'd5;
      #1;
      n_checks++;
      if (b_ready !== 1'b1) begin n_fail++; $display("FAIL zero_w_ready: got %b want 1", b_ready); end
      tick();
      b_width = 10'd5; b_height = 10'd0;
      #1;
      n_checks++;
      if ({b_ready, level, start} !== {1'b1, 5'd0, 1'b0}) begin
         n_fail++; $display("FAIL zero_h: ready=%b level=%0d start=%b want 1/0/0", b_ready, level, start);
      end
      tick();
      b_width = 10'd5; b_height = 10'd1;
      #1;
      n_checks++;
      if ({b_ready, level, busy} !== {1'b1, 5'd0, 1'b0}) begin
         n_fail++; $display("FAIL zero_valid_push: ready=%b level=%0d busy=%b want 1/0/0", b_ready, level, busy);
      end
      tick();
      b_valid = 1'b0;
      tick();
      n_checks++;
      if ({start, width, height} !== {1'b1, 10'd5, 10'd1}) begin
         n_fail++; $display("FAIL zero_launch: start=%b w=%0d h=%0d want 1/5/1", start, width, height);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      ns = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (start === 1'b1) ns++;
      end
      n_checks++;
      if ({ns, done_count} !== {32'd0, 16'd1}) begin
         n_fail++; $display("FAIL zero_totals: extra starts=%0d count=%0d want 0/1", ns, done_count);
      end
   endtask

   task automatic test_spurious_done();
      int ns;
      do_reset();
      done = 1'b1;
      tick();
      done = 1'b0;
      ns = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (start === 1'b1) ns++;
      end
      n_checks++;
      if ({ns, done_count} !== {32'd0, 16'd0}) begin
         n_fail++; $display("FAIL spur_idle: starts=%0d count=%0d want 0/0", ns, done_count);
      end
      a_valid = 1'b1; a_vram = 28'h300; a_width = 10'd7; a_height = 10'd7;
      tick();
      a_valid = 1'b0;
      tick();
      n_checks++;
      if (start !== 1'b1) begin n_fail++; $display("FAIL spur_launch: start=%b want 1", start); end
      tick(); tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      ns = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (start === 1'b1) ns++;
      end
      n_checks++;
      if ({ns, done_count} !== {32'd0, 16'd1}) begin
         n_fail++; $display("FAIL spur_gap: starts=%0d count=%0d want 0/1", ns, done_count);
      end
   endtask

   task automatic test_timeout();
      int cnt;
      do_reset();
      a_valid = 1'b1; a_vram = 28'h400; a_width = 10'd1; a_height = 10'd1;
      tick();
      a_valid = 1'b0;
      tick();
      for (int i = 0; i < int'(TIMEOUT); i++) tick();
      done = 1'b1;
      #1;
      n_checks++;
      if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_coincide_err: got %b want 0", err_timeout); end
      tick();
      done = 1'b0;
      n_checks++;
      if ({done_count, err_timeout} !== {16'd1, 1'b0}) begin
         n_fail++; $display("FAIL tmo_coincide: count=%0d err=%b want 1/0", done_count, err_timeout);
      end
      tick(); tick(); tick();
      a_valid = 1'b1; a_vram = 28'h500; a_width = 10'd2; a_height = 10'd2;
      tick();
      a_valid = 1'b0;
      b_valid = 1'b1; b_vram = 28'h600; b_width = 10'd3; b_height = 10'd3;
      tick();
      b_valid = 1'b0;
      n_checks++;
      if ({start, vram} !== {1'b1, 28'h500}) begin
         n_fail++; $display("FAIL tmo_launch: start=%b vram=%h want 1/500", start, vram);
      end
      for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
      n_checks++;
      if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_early: err=%b want 0", err_timeout); end
      tick();
      n_checks++;
      if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: err=%b want 1", err_timeout); end
      cnt = 0;
      while (start !== 1'b1 && cnt < 10) begin
         tick();
         cnt++;
      end
      n_checks++;
      if ({cnt, vram, err_timeout} !== {32'(GAP + 2), 28'h600, 1'b1}) begin
         n_fail++; $display("FAIL tmo_next: wait=%0d vram=%h err=%b want %0d/600/1", cnt, vram, err_timeout, GAP + 2);
      end
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if ({done_count, err_timeout} !== {16'd2, 1'b1}) begin
         n_fail++; $display("FAIL tmo_sticky: count=%0d err=%b want 2/1", done_count, err_timeout);
      end
   endtask

   task automatic test_reset_mid();
      int ns;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         a_valid = 1'b1; a_vram = 28'h800 + 28'(c); a_width = 10'd4; a_height = 10'd4;
         tick();
      end
      a_valid = 1'b0;
      n_checks++;
      if (level !== 5'd3) begin n_fail++; $display("FAIL mid_queued: level=%0d want 3", level); end
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({level, busy, vram} !== {5'd0, 1'b0, 28'h0}) begin
         n_fail++; $display("FAIL mid_flush: level=%0d busy=%b vram=%h want 0/0/0", level, busy, vram);
      end
      ns = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (start === 1'b1) ns++;
      end
      n_checks++;
      if (ns !== 0) begin n_fail++; $display("FAIL mid_no_start: starts=%0d want 0", ns); end
      a_valid = 1'b1; a_vram = 28'h900; a_width = 10'd1; a_height = 10'd1;
      tick();
      a_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (start !== 1'b0) begin n_fail++; $display("FAIL mid_start_suppress: start=%b want 0", start); end
      tick();
      rst = 1'b0;
      n_checks++;
      if ({busy, start} !== 2'b00) begin
         n_fail++; $display("FAIL mid_after_launch_rst: busy=%b start=%b want 0/0", busy, start);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_size();
      test_spurious_done();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
